// File: rtl/tank_health_bank_if.sv
// Bus bundle for tank_health_bank: per-tank event inputs from game logic and
// health/status outputs toward the HUD.
interface tank_health_bank_if #(
  parameter int unsigned N_TANKS  = 2,
  parameter int unsigned HEALTH_W = 6
);
  localparam int unsigned CountW = $clog2(N_TANKS + 1);

  logic [N_TANKS-1:0]          collision;
  logic [N_TANKS-1:0]          shield_on;
  logic [N_TANKS-1:0]          heal;
  logic [N_TANKS-1:0]          respawn;
  logic [N_TANKS*HEALTH_W-1:0] health;
  logic [N_TANKS-1:0]          tank_dead;
  logic [N_TANKS-1:0]          invuln;
  logic [N_TANKS-1:0]          hit_pulse;
  logic [CountW-1:0]           alive_count;

  modport master (
    output collision, shield_on, heal, respawn,
    input  health, tank_dead, invuln, hit_pulse, alive_count
  );

  modport slave (
    input  collision, shield_on, heal, respawn,
    output health, tank_dead, invuln, hit_pulse, alive_count
  );
endinterface

// File: rtl/tank_health_bank.sv
// Per-tank health tracker: edge-detected hits, shield masking, saturating damage/heal,
// post-hit invulnerability window and a dead state left only by respawn.
module tank_health_bank #(
  parameter int unsigned N_TANKS       = 2,
  parameter int unsigned HEALTH_W      = 6,
  parameter int unsigned MAX_HEALTH    = 50,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned HEAL_AMT      = 5,
  parameter int unsigned INVULN_CYCLES = 4
) (
  input logic               clock,
  input logic               reset,
  tank_health_bank_if.slave bus
);
  localparam int unsigned CntW   = $clog2(INVULN_CYCLES + 2);
  localparam int unsigned CountW = $clog2(N_TANKS + 1);

  localparam logic [HEALTH_W-1:0] MaxH    = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W:0]   MaxExt  = (HEALTH_W + 1)'(MAX_HEALTH);
  localparam logic [HEALTH_W:0]   DmgExt  = (HEALTH_W + 1)'(DAMAGE);
  localparam logic [HEALTH_W:0]   HealExt = (HEALTH_W + 1)'(HEAL_AMT);
  localparam logic [CntW-1:0]     InvLoad = CntW'(INVULN_CYCLES);

  typedef enum logic [1:0] {StAlive, StInvuln, StDead} state_e;

  state_e              state_q  [N_TANKS];
  state_e              state_d  [N_TANKS];
  logic [HEALTH_W-1:0] health_q [N_TANKS];
  logic [HEALTH_W-1:0] health_d [N_TANKS];
  logic [CntW-1:0]     cnt_q    [N_TANKS];
  logic [CntW-1:0]     cnt_d    [N_TANKS];
  logic [N_TANKS-1:0]  hit_q, hit_d;
  logic [N_TANKS-1:0]  col_prev_q;

  // col_prev resets high so a collision held through reset release is not a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TANKS; i++) begin
        state_q[i]  <= StAlive;
        health_q[i] <= MaxH;
        cnt_q[i]    <= '0;
      end
      hit_q      <= '0;
      col_prev_q <= '1;
    end else begin
      for (int i = 0; i < N_TANKS; i++) begin
        state_q[i]  <= state_d[i];
        health_q[i] <= health_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      hit_q      <= hit_d;
      col_prev_q <= bus.collision;
    end
  end

  always_comb begin
    logic              col_edge;
    logic [HEALTH_W:0] dmg_sub;
    logic [HEALTH_W:0] heal_sum;
    logic [HEALTH_W-1:0] dmg_res;
    logic [HEALTH_W-1:0] heal_res;
    col_edge = 1'b0;
    dmg_sub  = '0;
    heal_sum = '0;
    dmg_res  = '0;
    heal_res = '0;
    hit_d    = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      state_d[i]  = state_q[i];
      health_d[i] = health_q[i];
      cnt_d[i]    = cnt_q[i];

      col_edge = bus.collision[i] & ~col_prev_q[i];
      // Borrow out of the extended subtraction means the hit would go below zero.
      dmg_sub  = {1'b0, health_q[i]} - DmgExt;
      dmg_res  = dmg_sub[HEALTH_W] ? '0 : dmg_sub[HEALTH_W-1:0];
      heal_sum = {1'b0, health_q[i]} + HealExt;
      heal_res = (heal_sum > MaxExt) ? MaxH : heal_sum[HEALTH_W-1:0];

      unique case (state_q[i])
        StAlive: begin
          if (bus.respawn[i]) begin
            state_d[i] = StAlive;
          end else if (col_edge && !bus.shield_on[i]) begin
            health_d[i] = dmg_res;
            hit_d[i]    = 1'b1;
            if (dmg_res == '0) begin
              state_d[i] = StDead;
            end else if (INVULN_CYCLES > 0) begin
              state_d[i] = StInvuln;
              cnt_d[i]   = InvLoad;
            end
          end else if (bus.heal[i]) begin
            health_d[i] = heal_res;
          end
        end
        StInvuln: begin
          if (bus.heal[i]) health_d[i] = heal_res;
          cnt_d[i] = cnt_q[i] - 1'b1;
          if (cnt_q[i] <= CntW'(1)) state_d[i] = StAlive;
        end
        StDead: begin
          health_d[i] = '0;
          if (bus.respawn[i]) begin
            health_d[i] = MaxH;
            if (INVULN_CYCLES > 0) begin
              state_d[i] = StInvuln;
              cnt_d[i]   = InvLoad;
            end else begin
              state_d[i] = StAlive;
            end
          end
        end
        default: state_d[i] = StAlive;
      endcase
    end
  end

  always_comb begin
    bus.health      = '0;
    bus.tank_dead   = '0;
    bus.invuln      = '0;
    bus.hit_pulse   = hit_q;
    bus.alive_count = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      bus.health[i*HEALTH_W +: HEALTH_W] = health_q[i];
      bus.tank_dead[i] = (state_q[i] == StDead);
      bus.invuln[i]    = (state_q[i] == StInvuln);
      bus.alive_count  = bus.alive_count + CountW'(state_q[i] != StDead);
    end
  end
endmodule
